data_memory_hs: RTL
===================

Name: data_memory_hs

Overview:
Parametrised, clocked successor to the single-cycle data memory. It serves byte-addressed word accesses through a req/ready/ack handshake with a programmable access latency and per-byte write strobes. It sits behind the CPU's MEM stage, or a future cache refill path, and models a multi-cycle main memory. Out-of-range and misaligned accesses are flagged, never silently aliased.

Parameters:
DATA_WIDTH, 32, word width in bits; multiple of 8, at least 8
ADDR_WIDTH, 32, byte-address width
DEPTH, 1024, number of words; power of two
LATENCY, 4, cycles from request acceptance to ack; at least 1

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  asynchronous, active-low reset
req_i  in  1  request valid
we_i  in  1  1 = write, 0 = read
addr_i  in  ADDR_WIDTH  byte address
be_i  in  DATA_WIDTH/8  byte write enables; ignored on reads
data_i  in  DATA_WIDTH  write data
ready_o  out  1  block can accept a request this cycle
ack_o  out  1  one-cycle completion pulse
data_o  out  DATA_WIDTH  read data, valid while ack_o=1
err_o  out  1  access error, valid while ack_o=1

Behaviour:
- Reset (rst_i=0, asynchronous): state IDLE, counter 0, ready_o=1, ack_o=0, data_o=0, err_o=0.
- Memory contents are not reset (X in simulation).
- Reset asserted mid-access: the access is abandoned and no array write occurs.
- Word index: OFF=log2(DATA_WIDTH/8), IW=log2(DEPTH); idx = addr_i[OFF+IW-1:OFF].
- Error condition: addr_i[OFF-1:0] != 0 (misaligned), or any addr_i bit at or above OFF+IW set (out of range). Evaluated on the latched address.
- Handshake: accept when req_i && ready_o at a rising edge.
  - On acceptance, latch we, addr, be, data.
  - Inputs are ignored while not ready.
  - req_i while ready_o=0 is neither queued nor acknowledged; the master must hold or re-issue it.
- States:
  - IDLE: ready_o=1. On accept go to BUSY with cnt=LATENCY-1.
  - BUSY: ready_o=0. Each cycle, if cnt!=0 then cnt--. If cnt==0, perform the operation, register ack_o=1, return to IDLE.
- Timing: accept at edge T, ack_o high in the cycle following edge T+LATENCY, for exactly one cycle. With LATENCY=1, ack follows the cycle after acceptance.
- ready_o is already 1 during the ack cycle. A new request in that cycle is accepted, giving back-to-back throughput of one access per LATENCY+1 cycles.
- Write, no error: each byte lane k with be[k]=1 is updated; other lanes are unchanged. data_o=0 on write acks.
- Write with be=0: legal, no-op, normal ack.
- Read, no error: data_o = array word at idx, reflecting all previously acked writes.
- Error (read or write): no array write; data_o=0; err_o=1 with ack_o.
- Outside ack cycles: ack_o=0 and err_o=0; data_o holds its last value.
- No combinational path from any input to any output.

Decomposition:
- Package data_memory_pkg holds:
  - state enum {ST_IDLE, ST_BUSY};
  - helper functions for OFF/IW computation (clog2 wrappers);
  - a default-parameter localparam set shared with the CPU top.
- One sub-module, data_memory_array: a synchronous single-port RAM (DEPTH x DATA_WIDTH) with byte-enable write and registered read. The controller FSM, counter and error check stay in data_memory_hs.

Test Plan:
1. Reset then idle: rst_i low 3 cycles, release -> ready_o=1, ack_o=0, data_o=0, err_o=0; no ack without req.
2. Write then read, LATENCY=4: write addr 0x10, data 0xDEADBEEF, be=4'hF; ack 4 cycles after accept. Read 0x10 -> ack after 4 cycles, data_o=0xDEADBEEF, err_o=0.
3. Byte enables: write 0x10 with 0x11223344 and be=4'b0101, then read -> 0xDE22BE44.
4. Errors: read addr 0x12 (misaligned) and read 0x1000 (out of range, DEPTH=1024) -> ack with err_o=1, data_o=0. A write to 0x1000 leaves word 0 unchanged; verify by reading addr 0.
5. Back-to-back and busy: assert req_i continuously for 3 reads -> acks spaced LATENCY+1 cycles apart. A req_i toggled mid-BUSY with a different address is ignored and produces no extra ack.
6. Reset mid-write: accept write 0x20 = 0xCAFEF00D, pull rst_i low at cycle 2, release -> no ack. Reading 0x20 returns the prior contents (pre-written 0x0).

Source files
------------

// File: rtl/data_memory_hs_pkg.sv
// Shared definitions for the handshaked data memory.
// Holds the controller state encoding, helpers that derive the byte-offset
// and word-index field widths from the geometry, and the default geometry
// shared with the CPU top.
package data_memory_pkg;

  typedef enum logic {ST_IDLE, ST_BUSY} state_t;

  localparam int DM_DATA_WIDTH = 32;
  localparam int DM_ADDR_WIDTH = 32;
  localparam int DM_DEPTH      = 1024;
  localparam int DM_LATENCY    = 4;

  // Number of byte-offset bits inside one word.
  function automatic int off_bits(input int data_width);
    return $clog2(data_width / 8);
  endfunction

  // Number of word-index bits for the given number of words.
  function automatic int idx_bits(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/data_memory_hs_if.sv
// Request/ready/ack bus between a master and the handshaked data memory.
// Master drives req_i, we_i, addr_i, be_i, data_i.
// Memory drives ready_o, ack_o, data_o, err_o.
interface data_memory_hs_if import data_memory_pkg::*; #(
  parameter int DATA_WIDTH = DM_DATA_WIDTH,
  parameter int ADDR_WIDTH = DM_ADDR_WIDTH
);
  logic                    req_i;
  logic                    we_i;
  logic [ADDR_WIDTH-1:0]   addr_i;
  logic [DATA_WIDTH/8-1:0] be_i;
  logic [DATA_WIDTH-1:0]   data_i;
  logic                    ready_o;
  logic                    ack_o;
  logic [DATA_WIDTH-1:0]   data_o;
  logic                    err_o;

  modport master (
    output req_i, we_i, addr_i, be_i, data_i,
    input  ready_o, ack_o, data_o, err_o
  );

  modport slave (
    input  req_i, we_i, addr_i, be_i, data_i,
    output ready_o, ack_o, data_o, err_o
  );
endinterface

// File: rtl/data_memory_hs_array.sv
// Synchronous single-port RAM, DEPTH x DATA_WIDTH, byte-enable write and
// registered read. Contents are not reset.
// Ports: clk_i clock; i_en access enable; i_we write select; i_be byte
// enables; i_addr word index; i_wdata write data; o_rdata registered read
// data (updates only on an enabled read).
module data_memory_array #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 1024,
  parameter int IW         = 10
) (
  input  logic                    clk_i,
  input  logic                    i_en,
  input  logic                    i_we,
  input  logic [DATA_WIDTH/8-1:0] i_be,
  input  logic [IW-1:0]           i_addr,
  input  logic [DATA_WIDTH-1:0]   i_wdata,
  output logic [DATA_WIDTH-1:0]   o_rdata
);
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_rdata;

  always_ff @(posedge clk_i) begin
    if (i_en) begin
      if (i_we) begin
        for (int k = 0; k < DATA_WIDTH/8; k++) begin
          if (i_be[k]) r_mem[i_addr][k*8 +: 8] <= i_wdata[k*8 +: 8];
        end
      end else begin
        r_rdata <= r_mem[i_addr];
      end
    end
  end

  assign o_rdata = r_rdata;
endmodule

// File: rtl/data_memory_hs.sv
// Multi-cycle data memory behind a req/ready/ack handshake.
// A request accepted at edge T is completed at edge T+LATENCY; ack_o is a
// one-cycle pulse in the following cycle, with err_o for misaligned or
// out-of-range addresses and data_o carrying read data.
// Ports: clk_i clock; rst_i asynchronous active-low reset; bus slave side of
// data_memory_hs_if (req/we/addr/be/data in, ready/ack/data/err out).
module data_memory_hs import data_memory_pkg::*; #(
  parameter int DATA_WIDTH = DM_DATA_WIDTH,
  parameter int ADDR_WIDTH = DM_ADDR_WIDTH,
  parameter int DEPTH      = DM_DEPTH,
  parameter int LATENCY    = DM_LATENCY
) (
  input  logic              clk_i,
  input  logic              rst_i,
  data_memory_hs_if.slave   bus
);
  localparam int BE_W  = DATA_WIDTH / 8;
  localparam int OFF   = off_bits(DATA_WIDTH);
  localparam int IW    = idx_bits(DEPTH);
  localparam int CNT_W = $clog2(LATENCY + 1);
  localparam logic [ADDR_WIDTH-1:0] LO_MASK = ADDR_WIDTH'((64'd1 << OFF) - 64'd1);

  state_t                r_state;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_ready;
  logic                  r_ack;
  logic                  r_err;
  logic                  r_src_ram;
  logic                  r_we;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [BE_W-1:0]       r_be;
  logic [DATA_WIDTH-1:0] r_wdata;

  logic                  w_accept;
  logic                  w_last;
  logic                  w_err;
  logic                  w_do_op;
  logic [IW-1:0]         w_idx;
  logic [DATA_WIDTH-1:0] w_rdata;

  assign w_accept = r_ready & bus.req_i;
  assign w_last   = (r_state == ST_BUSY) && (r_cnt == '0);
  // Misaligned if any byte-offset bit is set; out of range if any bit above
  // the word index is set. Both use the latched address only.
  assign w_err    = (|(r_addr & LO_MASK)) | (|(r_addr >> (OFF + IW)));
  assign w_idx    = r_addr[OFF+IW-1:OFF];
  // The array is only touched on the completing edge of a legal access, so
  // an access abandoned by reset never reaches it.
  assign w_do_op  = w_last & ~w_err;

  // Request latch: data-only, not reset.
  always_ff @(posedge clk_i) begin
    if (w_accept) begin
      r_we    <= bus.we_i;
      r_addr  <= bus.addr_i;
      r_be    <= bus.be_i;
      r_wdata <= bus.data_i;
    end
  end

  // Controller FSM with registered handshake outputs.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_ready   <= 1'b1;
      r_ack     <= 1'b0;
      r_err     <= 1'b0;
      r_src_ram <= 1'b0;
    end else begin
      r_ack <= 1'b0;
      r_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_state <= ST_BUSY;
            r_cnt   <= CNT_W'(LATENCY - 1);
            r_ready <= 1'b0;
          end
        end
        ST_BUSY: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
          end else begin
            r_state   <= ST_IDLE;
            r_ready   <= 1'b1;
            r_ack     <= 1'b1;
            r_err     <= w_err;
            // Read data comes from the RAM output register; writes and
            // errors present zero. The selection holds until the next ack.
            r_src_ram <= ~r_we & ~w_err;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  data_memory_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .IW         (IW)
  ) u_array (
    .clk_i   (clk_i),
    .i_en    (w_do_op),
    .i_we    (r_we),
    .i_be    (r_be),
    .i_addr  (w_idx),
    .i_wdata (r_wdata),
    .o_rdata (w_rdata)
  );

  assign bus.ready_o = r_ready;
  assign bus.ack_o   = r_ack;
  assign bus.err_o   = r_err;
  assign bus.data_o  = r_src_ram ? w_rdata : '0;
endmodule
